dc_rep_upload_q: RTL and testbench

Parametrised, double-buffered reply upload serializer for the directory-cache reply path. Accepts a whole reply message (up to MAX_FLITS flits of FLIT_W bits, length set by a separately loaded flit count) and streams it one flit per cycle into the reply FIFO under ready/valid backpressure, tagging each flit head/body/tail. A two-entry message queue lets the next reply be accepted while the current one is still draining, giving zero-bubble back-to-back messages.

---
 rtl/dc_rep_upload_q.sv | 130 +++++++++++++
 tb/tb_dc_rep_upload_q.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dc_rep_upload_q.sv
// Double-buffered reply upload serializer: a two-entry message queue drained one flit per
// cycle into the reply FIFO, tagging each flit as head/body/tail.
module dc_rep_upload_q #(
    parameter int unsigned FLIT_W    = 16,
    parameter int unsigned MAX_FLITS = 11,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [FLIT_W*MAX_FLITS-1:0] dc_flits_rep_i,
    input  logic                        v_dc_flits_rep_i,
    output logic                        dc_rep_rdy_o,
    input  logic [CNT_W-1:0]            flits_max_i,
    input  logic                        en_flits_max_i,
    input  logic                        rep_fifo_rdy_i,
    output logic [FLIT_W-1:0]           dc_flit_out_o,
    output logic                        v_dc_flit_out_o,
    output logic [1:0]                  dc_ctrl_out_o,
    output logic                        dc_rep_upload_state_o
);

    localparam int unsigned      MsgW    = FLIT_W * MAX_FLITS;
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(MAX_FLITS - 1);

    logic [MsgW-1:0]  msg_q  [2];
    logic [MsgW-1:0]  msg_d  [2];
    logic [CNT_W-1:0] mlen_q [2];
    logic [CNT_W-1:0] mlen_d [2];
    logic             hd_q, hd_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic [CNT_W-1:0]  flits_clamp;
    logic [CNT_W-1:0]  push_len;
    logic [FLIT_W-1:0] flit;
    logic              head_v;
    logic              push;
    logic              pop;
    logic              xfer;
    logic              last;
    logic              tl;

    always_comb begin
        flits_clamp = (flits_max_i > LastIdx) ? LastIdx : flits_max_i;
        push_len    = en_flits_max_i ? flits_clamp : len_q;
        head_v      = (cnt_q != 2'd0);
        push        = v_dc_flits_rep_i && (cnt_q != 2'd2);
        xfer        = head_v && rep_fifo_rdy_i;
        last        = (idx_q == mlen_q[hd_q]);
        pop         = xfer && last;
        // Tail slot is the head slot when empty, the other slot when one entry is held.
        tl          = hd_q ^ cnt_q[0];
    end

    always_comb begin
        msg_d  = msg_q;
        mlen_d = mlen_q;
        hd_d   = hd_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        len_d  = en_flits_max_i ? flits_clamp : len_q;

        if (push) begin
            msg_d[tl]  = dc_flits_rep_i;
            mlen_d[tl] = push_len;
        end

        if (xfer) begin
            if (last) begin
                idx_d = '0;
                hd_d  = ~hd_q;
            end else begin
                idx_d = idx_q + CNT_W'(1);
            end
        end

        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hd_q  <= 1'b0;
            cnt_q <= 2'd0;
            idx_q <= '0;
            len_q <= '0;
        end else begin
            hd_q  <= hd_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            len_q <= len_d;
        end
    end

    // Payload storage needs no reset: it is only observed while its entry is valid.
    always_ff @(posedge clk_i) begin
        msg_q  <= msg_d;
        mlen_q <= mlen_d;
    end

    always_comb begin
        flit = '0;
        for (int unsigned i = 0; i < MAX_FLITS; i++) begin
            if (idx_q == CNT_W'(i)) begin
                flit = msg_q[hd_q][(MAX_FLITS-1-i)*FLIT_W +: FLIT_W];
            end
        end
    end

    always_comb begin
        dc_rep_rdy_o          = (cnt_q != 2'd2);
        dc_rep_upload_state_o = head_v;
        v_dc_flit_out_o       = head_v;
        dc_flit_out_o         = head_v ? flit : '0;
        if (!head_v) begin
            dc_ctrl_out_o = 2'b00;
        end else if (last) begin
            dc_ctrl_out_o = 2'b11;
        end else if (idx_q == '0) begin
            dc_ctrl_out_o = 2'b01;
        end else begin
            dc_ctrl_out_o = 2'b10;
        end
    end

endmodule

// File: tb/tb_dc_rep_upload_q.sv
// Bench for dc_rep_upload_q: directed scenarios plus random traffic, every output compared
// each cycle against a queue-based message model.
module tb_dc_rep_upload_q;

    localparam int FW = 16;
    localparam int MF = 11;
    localparam int CW = 4;
    localparam int MW = FW * MF;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] msg;
    logic          v_in;
    logic          rdy;
    logic [CW-1:0] fm;
    logic          en;
    logic          fifo_rdy;
    logic [FW-1:0] flit;
    logic          v_out;
    logic [1:0]    ctrl;
    logic          state;

    int n_chk  = 0;
    int n_fail = 0;
    int n_xfer;

    logic [MW-1:0] mq_msg [$];
    int            mq_len [$];
    int            m_pos  = 0;
    int            m_plen = 0;

    dc_rep_upload_q #(.FLIT_W(FW), .MAX_FLITS(MF), .CNT_W(CW)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .dc_flits_rep_i        (msg),
        .v_dc_flits_rep_i      (v_in),
        .dc_rep_rdy_o          (rdy),
        .flits_max_i           (fm),
        .en_flits_max_i        (en),
        .rep_fifo_rdy_i        (fifo_rdy),
        .dc_flit_out_o         (flit),
        .v_dc_flit_out_o       (v_out),
        .dc_ctrl_out_o         (ctrl),
        .dc_rep_upload_state_o (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] mk_msg(input logic [FW-1:0] base, input logic [FW-1:0] step);
        logic [MW-1:0] m;
        logic [FW-1:0] f;
        m = '0;
        f = base;
        for (int i = 0; i < MF; i++) begin
            m = {m[MW-FW-1:0], f};
            f = f + step;
        end
        return m;
    endfunction

    // Compare outputs with the model, then advance model and DUT by one clock.
    task automatic cycle();
        logic [MW-1:0] sh;
        logic [FW-1:0] e_flit;
        logic [1:0]    e_ctrl;
        int            l;
        if (mq_msg.size() == 0) begin
            e_flit = '0;
            e_ctrl = 2'b00;
        end else begin
            sh     = mq_msg[0] >> ((MF - 1 - m_pos) * FW);
            e_flit = sh[FW-1:0];
            e_ctrl = (m_pos == mq_len[0]) ? 2'b11 : (m_pos == 0) ? 2'b01 : 2'b10;
        end
        check("flit",  32'(flit),  32'(e_flit));
        check("ctrl",  32'(ctrl),  32'(e_ctrl));
        check("valid", 32'(v_out), 32'(mq_msg.size() != 0));
        check("rdy",   32'(rdy),   32'(mq_msg.size() < 2));
        check("state", 32'(state), 32'(mq_msg.size() != 0));
        if (v_out && fifo_rdy) n_xfer++;

        if (rst) begin
            mq_msg.delete();
            mq_len.delete();
            m_pos  = 0;
            m_plen = 0;
        end else begin
            automatic bit can_push = (mq_msg.size() < 2);
            l = en ? ((int'(fm) > MF - 1) ? MF - 1 : int'(fm)) : m_plen;
            if (en) m_plen = l;
            if (mq_msg.size() != 0 && fifo_rdy) begin
                if (m_pos == mq_len[0]) begin
                    void'(mq_msg.pop_front());
                    void'(mq_len.pop_front());
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (v_in && can_push) begin
                mq_msg.push_back(msg);
                mq_len.push_back(l);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [MW-1:0] m, input logic e,
                         input logic [CW-1:0] f, input logic fr);
        v_in     = v;
        msg      = m;
        en       = e;
        fm       = f;
        fifo_rdy = fr;
        cycle();
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, fr);
    endtask

    initial begin
        rst = 1'b1; v_in = 1'b0; msg = '0; en = 1'b0; fm = '0; fifo_rdy = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        idle(2, 1'b1);

        // Single-flit message
        drive(1'b0, '0, 1'b1, 4'd0, 1'b1);
        drive(1'b1, mk_msg(16'h2011, 16'hffff), 1'b0, 4'd0, 1'b1);
        idle(3, 1'b1);

        // Nine flits with two backpressure windows
        drive(1'b0, '0, 1'b1, 4'd8, 1'b1);
        drive(1'b1, mk_msg(16'hc0de, 16'h0100), 1'b0, 4'd0, 1'b1);
        idle(3, 1'b1);
        idle(4, 1'b0);
        idle(4, 1'b1);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // Back-to-back three-flit messages
        drive(1'b0, '0, 1'b1, 4'd2, 1'b1);
        drive(1'b1, mk_msg(16'haa00, 16'h0001), 1'b0, 4'd0, 1'b1);
        drive(1'b1, mk_msg(16'hbb00, 16'h0001), 1'b0, 4'd0, 1'b1);
        idle(7, 1'b1);

        // Queue full: third push dropped, exactly 22 flits follow
        drive(1'b0, '0, 1'b1, 4'd10, 1'b0);
        drive(1'b1, mk_msg(16'h1100, 16'h0001), 1'b0, 4'd0, 1'b0);
        drive(1'b1, mk_msg(16'h2200, 16'h0001), 1'b0, 4'd0, 1'b0);
        drive(1'b1, mk_msg(16'h3300, 16'h0001), 1'b0, 4'd0, 1'b0);
        n_xfer = 0;
        idle(26, 1'b1);
        check("full_xfers", 32'(n_xfer), 32'd22);

        // Clamp with same-cycle length load
        n_xfer = 0;
        drive(1'b1, mk_msg(16'h4400, 16'h0001), 1'b1, 4'd15, 1'b1);
        idle(13, 1'b1);
        check("clamp_xfers", 32'(n_xfer), 32'd11);

        // Reset mid-message, then a fresh single-flit message
        drive(1'b1, mk_msg(16'h5500, 16'h0001), 1'b1, 4'd10, 1'b1);
        idle(4, 1'b1);
        rst = 1'b1;
        idle(1, 1'b1);
        rst = 1'b0;
        idle(1, 1'b1);
        drive(1'b1, mk_msg(16'h6600, 16'h0001), 1'b1, 4'd0, 1'b1);
        idle(3, 1'b1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic [MW-1:0] r;
            for (int k = 0; k < MF; k++) r[k*FW +: FW] = FW'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 2) != 0), r, ($urandom_range(0, 3) == 0),
                  CW'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        idle(30, 1'b1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
